prefetch_queue: RTL

// Parametrised instruction prefetch queue. Replaces the fixed 4-stage shift chain between program memory and the decoder.

---
 rtl/prefetch_queue_if.sv | 40 ++++
 rtl/prefetch_queue.sv | 124 ++++++++++++
 2 files changed

// File: rtl/prefetch_queue_if.sv
`default_nettype none
// ============================================================================
// prefetch_queue_if : fetch-memory and decoder handshake bundle
// Rev 1.0
// ============================================================================
interface prefetch_queue_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 16,
  parameter int DEPTH     = 4
);
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic                 flush;
  logic [ADDR_SIZE-1:0] flush_addr;
  logic                 fetch_req;
  logic [ADDR_SIZE-1:0] fetch_addr;
  logic                 mem_ready;
  logic                 mem_valid;
  logic [WORD_SIZE-1:0] mem_data;
  logic                 dec_valid;
  logic                 dec_ready;
  logic [WORD_SIZE-1:0] dec_data;
  logic [ADDR_SIZE-1:0] dec_pc;
  logic                 pre_valid;
  logic [WORD_SIZE-1:0] pre_data;
  logic [c_cnt_w-1:0]   count;

  modport master (
    input  flush, flush_addr, mem_ready, mem_valid, mem_data, dec_ready,
    output fetch_req, fetch_addr, dec_valid, dec_data, dec_pc,
           pre_valid, pre_data, count
  );

  modport slave (
    output flush, flush_addr, mem_ready, mem_valid, mem_data, dec_ready,
    input  fetch_req, fetch_addr, dec_valid, dec_data, dec_pc,
           pre_valid, pre_data, count
  );
endinterface
`default_nettype wire

// File: rtl/prefetch_queue.sv
`default_nettype none
// ============================================================================
// prefetch_queue : sequential instruction prefetcher with DEPTH-entry FIFO
// Rev 1.0
// ============================================================================
module prefetch_queue #(
  parameter int                   WORD_SIZE  = 16,
  parameter int                   ADDR_SIZE  = 16,
  parameter int                   DEPTH      = 4,
  parameter logic [ADDR_SIZE-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset,
  prefetch_queue_if.master bus
);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_two   = c_cnt_w'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_fetch_en;
  logic [ADDR_SIZE-1:0] r_pc;
  logic [ADDR_SIZE-1:0] r_req_addr;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [WORD_SIZE-1:0] r_data_mem [DEPTH];
  logic [ADDR_SIZE-1:0] r_pc_mem   [DEPTH];

  logic                 w_push;
  logic                 w_pop;
  logic                 w_issue;
  logic                 w_dec_valid;
  logic                 w_pre_valid;
  logic [c_ptr_w-1:0]   w_pre_ptr;
  logic [c_cnt_w-1:0]   w_count_nxt;

  // Flush overrides both FIFO ports so a discarded word or pop never lands.
  assign w_push      = (r_state == S_WAIT) & bus.mem_valid & ~bus.flush;
  assign w_pop       = w_dec_valid & bus.dec_ready & ~bus.flush;
  assign w_issue     = bus.fetch_req & bus.mem_ready;
  assign w_dec_valid = (r_count != '0);
  assign w_pre_valid = (r_count >= c_two);
  assign w_pre_ptr   = r_rd_ptr + c_ptr_w'(1);
  assign w_count_nxt = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

  // r_fetch_en is precomputed for the next cycle: IDLE with a free slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_fetch_en <= 1'b0;
      r_pc       <= RESET_ADDR;
      r_req_addr <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (bus.flush) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_pc     <= bus.flush_addr;
      if ((r_state == S_IDLE) || bus.mem_valid) begin
        r_state    <= S_IDLE;
        r_fetch_en <= 1'b1;
      end else begin
        r_state    <= S_DROP;
        r_fetch_en <= 1'b0;
      end
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state    <= S_WAIT;
            r_req_addr <= r_pc;
            r_pc       <= r_pc + ADDR_SIZE'(1);
            r_fetch_en <= 1'b0;
          end else begin
            r_fetch_en <= (w_count_nxt < c_depth);
          end
        end
        S_WAIT, S_DROP: begin
          if (bus.mem_valid) begin
            r_state    <= S_IDLE;
            r_fetch_en <= (w_count_nxt < c_depth);
          end else begin
            r_fetch_en <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_fetch_en <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr] <= bus.mem_data;
      r_pc_mem[r_wr_ptr]   <= r_req_addr;
    end
  end

  assign bus.fetch_req  = r_fetch_en & ~bus.flush;
  assign bus.fetch_addr = r_pc;
  assign bus.count      = r_count;
  assign bus.dec_valid  = w_dec_valid;
  assign bus.pre_valid  = w_pre_valid;
  // Gating by occupancy keeps the data outputs at zero while reset or empty.
  assign bus.dec_data   = w_dec_valid ? r_data_mem[r_rd_ptr] : '0;
  assign bus.dec_pc     = w_dec_valid ? r_pc_mem[r_rd_ptr]   : '0;
  assign bus.pre_data   = w_pre_valid ? r_data_mem[w_pre_ptr] : '0;
endmodule
`default_nettype wire
